// File: rtl/sram_fifo_wr_packer_if.sv
// ---------------------------------------------------------------------------
// sram_fifo_wr_packer_if
//
// Bundles the two handshakes that pass through the write packer: the narrow
// input beat stream and the full-width row push toward the SRAM FIFO.
//
// Handshake rules, for both channels:
//   - Input stream: a beat transfers on a rising edge where in_valid and
//     in_ready are both high. in_last travels with the beat.
//   - Row push: a row transfers on a rising edge where wr_req and wr_ack are
//     both high. Once wr_req rises, it and wr_data stay stable until that
//     transfer. wr_ack is the FIFO's same-cycle response to wr_req, and
//     wr_ack without wr_req has no effect.
//
// Modports:
//   master : the environment side. It drives beats and wr_ack, and observes
//            in_ready and the row push.
//   slave  : the packer side. It consumes beats and drives in_ready,
//            wr_req and wr_data.
//
// Parameters:
//   IN_WIDTH  : input beat width.
//   OUT_WIDTH : packed row width.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface sram_fifo_wr_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 wr_req;
  logic [OUT_WIDTH-1:0] wr_data;
  logic                 wr_ack;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  wr_req,
    input  wr_data,
    output wr_ack
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output wr_req,
    output wr_data,
    input  wr_ack
  );
endinterface

// File: rtl/sram_fifo_wr_packer.sv
// ---------------------------------------------------------------------------
// sram_fifo_wr_packer
//
// Upstream feeder for the SRAM-backed FIFO. The block collects OUT_WIDTH/IN_WIDTH
// narrow beats into one full-width row, using little-endian lane order, so
// beat k lands in lane k. It then pushes the row into the FIFO with a
// wr_req/wr_ack handshake.
//
// A one-row hold register decouples collection from the push. While a row
// waits for wr_ack, the next row keeps filling. Only its final lane stalls,
// and only if the previous row is still unacknowledged.
//
// Ports:
//   clk          : single clock; all logic is on the rising edge.
//   rst_n        : asynchronous active-low reset. It discards any partial
//                  row and any pending row.
//   bus          : sram_fifo_wr_packer_if.slave. Carries the input beat
//                  stream and the row push to the FIFO.
//   words_pushed : count of rows accepted by the FIFO. Wraps at 16 bits.
//   busy         : high while a partial row is being collected or a row is
//                  pending.
//
// Parameters:
//   IN_WIDTH  : input beat width (default 8).
//   OUT_WIDTH : row width (default 32). Must be an integer multiple of
//               IN_WIDTH, with a ratio of at least 2.
//
// Build option:
//   PACKER_LAST_PAD_EN : when defined, an accepted beat with in_last closes
//                        the row early. The lanes above it are zero-filled.
//                        When undefined, in_last is ignored.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_fifo_wr_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sram_fifo_wr_packer_if.slave      bus,
  output logic [15:0]               words_pushed,
  output logic                      busy
);

  localparam int BEATS  = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int PACK_W = OUT_WIDTH - IN_WIDTH;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BEATS - 1);

  // Row occupancy. A row can be collecting while another row is pending,
  // so the two flags are independent. The enum names the four combinations.
  typedef enum logic [1:0] {
    ROW_EMPTY        = 2'b00,
    ROW_COLLECT      = 2'b01,
    ROW_PEND         = 2'b10,
    ROW_COLLECT_PEND = 2'b11
  } row_state_t;

  // Registered state and its next-state values.
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic [PACK_W-1:0]    pack_reg, pack_nxt;
  logic                 out_val,  out_val_nxt;
  logic [OUT_WIDTH-1:0] out_reg,  out_reg_nxt;
  logic [15:0]          push_cnt, push_cnt_nxt;

  // Per-cycle decode.
  logic                 last_beat;
  logic                 final_lane;
  logic                 accept;
  logic                 close_row;
  logic                 push_done;
  logic [OUT_WIDTH-1:0] row;
  row_state_t           row_state;

`ifdef PACKER_LAST_PAD_EN
  assign last_beat = bus.in_last;
`else
  // in_last has no function in this build.
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign last_beat      = 1'b0;
`endif

  // A beat that would close a row needs the hold register free.
  // in_ready is built from registered state, plus in_last, which travels
  // with the beat. It never depends on wr_ack. As a result, a row being
  // acknowledged this cycle frees the hold register only from the next
  // cycle onward.
  assign final_lane   = (beat_cnt == LAST_LANE) | last_beat;
  assign bus.in_ready = ~final_lane | ~out_val;

  assign accept    = bus.in_valid & bus.in_ready;
  assign close_row = accept & final_lane;
  assign push_done = out_val & bus.wr_ack;

  assign bus.wr_req  = out_val;
  assign bus.wr_data = out_reg;

  // Assemble the closing row from the lanes collected so far. The incoming
  // beat goes in lane beat_cnt. Lanes above it are zero, which only matters
  // for an early in_last close. A full row reduces to {in_data, pack_reg}.
  // Stale lanes left in pack_reg by an earlier short row are masked out
  // here rather than cleared.
  always_comb begin
    row = '0;
    for (int j = 0; j < BEATS - 1; j++) begin
      if (CNT_W'(j) < beat_cnt) begin
        row[j*IN_WIDTH +: IN_WIDTH] = pack_reg[j*IN_WIDTH +: IN_WIDTH];
      end
    end
    for (int j = 0; j < BEATS; j++) begin
      if (CNT_W'(j) == beat_cnt) begin
        row[j*IN_WIDTH +: IN_WIDTH] = bus.in_data;
      end
    end
  end

  // Next-state logic for the collect and hold stages.
  always_comb begin
    beat_cnt_nxt = beat_cnt;
    pack_nxt     = pack_reg;
    out_val_nxt  = out_val;
    out_reg_nxt  = out_reg;
    push_cnt_nxt = push_cnt;

    if (push_done) begin
      out_val_nxt  = 1'b0;
      push_cnt_nxt = push_cnt + 16'd1;
    end

    if (accept) begin
      if (close_row) begin
        // A row loading in the same cycle as an ack overrides the clear.
        // Because in_ready stalls a closing beat while out_val is set, this
        // only happens when out_val was already 0.
        beat_cnt_nxt = '0;
        out_val_nxt  = 1'b1;
        out_reg_nxt  = row;
      end else begin
        beat_cnt_nxt = beat_cnt + CNT_W'(1);
        for (int j = 0; j < BEATS - 1; j++) begin
          if (CNT_W'(j) == beat_cnt) begin
            pack_nxt[j*IN_WIDTH +: IN_WIDTH] = bus.in_data;
          end
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pack_reg <= '0;
      out_val  <= 1'b0;
      out_reg  <= '0;
      push_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt_nxt;
      pack_reg <= pack_nxt;
      out_val  <= out_val_nxt;
      out_reg  <= out_reg_nxt;
      push_cnt <= push_cnt_nxt;
    end
  end

  // Row occupancy decode.
  always_comb begin
    row_state = ROW_EMPTY;
    case ({out_val, beat_cnt != '0})
      2'b01:   row_state = ROW_COLLECT;
      2'b10:   row_state = ROW_PEND;
      2'b11:   row_state = ROW_COLLECT_PEND;
      default: row_state = ROW_EMPTY;
    endcase
  end

  assign busy         = (row_state != ROW_EMPTY);
  assign words_pushed = push_cnt;

endmodule
